sdram_port_arb: RTL and testbench

SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

---
 rtl/sdram_arb_pkg.sv | 18 +
 rtl/sdram_rr_pick.sv | 39 +++
 rtl/sdram_port_arb.sv | 172 +++++++++++++++++
 tb/tb_sdram_port_arb.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter: default geometry, the
// burst-length field width used on the controller side, and FSM encodings.
package sdram_arb_pkg;

   // sdram_para: default arbiter geometry and controller field widths
   localparam int SDRAM_N_PORTS_DEF = 4;
   localparam int SDRAM_ADDR_W_DEF  = 22;
   localparam int SDRAM_BYTE_W      = 9;   // burst length 1..256

   // Arbiter transaction states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin picker: scans requests starting at the port
// after last_grant_i (wrapping modulo N_PORTS) and returns the first one.
module sdram_rr_pick
   import sdram_arb_pkg::*;
#(
   parameter int N_PORTS = SDRAM_N_PORTS_DEF,
   parameter int IDX_W   = $clog2(N_PORTS)
) (
   input  logic [N_PORTS-1:0] req_i,
   input  logic [IDX_W-1:0]   last_grant_i,
   output logic [N_PORTS-1:0] winner_o,
   output logic [IDX_W-1:0]   winner_idx_o,
   output logic               valid_o
);

   // Priority scan from last_grant_i+1 around to last_grant_i itself
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      // NOTE: every output gets a default before the loop so no path leaves
      // a variable unassigned, which would otherwise infer a latch.
      winner_o     = '0;
      winner_idx_o = '0;
      valid_o      = 1'b0;
      cand         = 0;
      cand_idx     = '0;
      for (int k = 1; k <= N_PORTS; k++) begin
         cand = int'(last_grant_i) + k;
         if (cand >= N_PORTS) cand = cand - N_PORTS;
         cand_idx = IDX_W'(cand);
         if (!valid_o && req_i[cand_idx]) begin
            valid_o            = 1'b1;
            winner_o[cand_idx] = 1'b1;
            winner_idx_o       = cand_idx;
         end
      end
   end

endmodule

// File: rtl/sdram_port_arb.sv
// Multi-port SDRAM access arbiter. Grants one requester at a time, issues
// its read/write burst to the controller, routes the controller's data
// strobes back to the owner and pulses port_done when the burst completes.
// A busy period without any ack (refresh) causes the same grant to re-issue.
// Build option: define SDRAM_ARB_PRIO_EN to give port 0 absolute priority,
// with the remaining ports round-robin among themselves.
module sdram_port_arb
   import sdram_arb_pkg::*;
#(
   parameter int N_PORTS = SDRAM_N_PORTS_DEF,
   parameter int ADDR_W  = SDRAM_ADDR_W_DEF
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [N_PORTS-1:0]                port_req,
   input  logic [N_PORTS-1:0]                port_r_wn,
   input  logic [SDRAM_BYTE_W*N_PORTS-1:0]   port_byte,
   input  logic [ADDR_W*N_PORTS-1:0]         port_addr,
   output logic [N_PORTS-1:0]                port_wr_ack,
   output logic [N_PORTS-1:0]                port_rd_ack,
   output logic [N_PORTS-1:0]                port_done,
   output logic                              sdram_wr_req,
   output logic                              sdram_rd_req,
   output logic [SDRAM_BYTE_W-1:0]           sdwr_byte,
   output logic [SDRAM_BYTE_W-1:0]           sdrd_byte,
   output logic [ADDR_W-1:0]                 sdram_addr,
   input  logic                              sdram_wr_ack,
   input  logic                              sdram_rd_ack,
   input  logic                              sdram_busy,
   input  logic                              sdram_init_done,
   output logic [N_PORTS-1:0]                grant
);

   localparam int IDX_W = $clog2(N_PORTS);

   arb_state_e                state_q, state_d;
   logic [N_PORTS-1:0]        grant_q, grant_d;
   logic [IDX_W-1:0]          grant_idx_q, grant_idx_d;
   logic [IDX_W-1:0]          last_q, last_d;
   logic                      served_q, served_d;
   logic                      r_wn_q, r_wn_d;
   logic [SDRAM_BYTE_W-1:0]   byte_q, byte_d;
   logic [ADDR_W-1:0]         addr_q, addr_d;

   logic [N_PORTS-1:0]        pick_req, pick_oh;
   logic [IDX_W-1:0]          pick_idx;
   logic                      pick_valid;
   logic [N_PORTS-1:0]        win_oh;
   logic [IDX_W-1:0]          win_idx;
   logic                      win_valid;
   logic                      sel_r_wn;
   logic [SDRAM_BYTE_W-1:0]   sel_byte;
   logic [ADDR_W-1:0]         sel_addr;

   sdram_rr_pick #(
      .N_PORTS (N_PORTS),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req_i        (pick_req),
      .last_grant_i (last_q),
      .winner_o     (pick_oh),
      .winner_idx_o (pick_idx),
      .valid_o      (pick_valid)
   );

`ifdef SDRAM_ARB_PRIO_EN
   // Port 0 overrides; round-robin only arbitrates among ports 1..N-1
   assign pick_req  = {port_req[N_PORTS-1:1], 1'b0};
   assign win_valid = port_req[0] | pick_valid;
   assign win_oh    = port_req[0] ? N_PORTS'(1) : pick_oh;
   assign win_idx   = port_req[0] ? '0 : pick_idx;
`else
   assign pick_req  = port_req;
   assign win_valid = pick_valid;
   assign win_oh    = pick_oh;
   assign win_idx   = pick_idx;
`endif

   // Mux the winner's direction, burst length and address out of the packed buses
   always_comb begin
      sel_r_wn = 1'b0;
      sel_byte = '0;
      sel_addr = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         if (win_oh[p]) begin
            sel_r_wn = port_r_wn[p];
            sel_byte = port_byte[p*SDRAM_BYTE_W +: SDRAM_BYTE_W];
            sel_addr = port_addr[p*ADDR_W +: ADDR_W];
         end
      end
   end

   // State and transaction registers; async reset aborts any burst in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         grant_idx_q <= '0;
         last_q      <= IDX_W'(N_PORTS - 1);
         served_q    <= 1'b0;
         r_wn_q      <= 1'b0;
         byte_q      <= '0;
         addr_q      <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values of the others.
         state_q     <= state_d;
         grant_q     <= grant_d;
         grant_idx_q <= grant_idx_d;
         last_q      <= last_d;
         served_q    <= served_d;
         r_wn_q      <= r_wn_d;
         byte_q      <= byte_d;
         addr_q      <= addr_d;
      end
   end

   // Next-state logic: grant in IDLE, issue until busy, wait for acks, finish
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      grant_idx_d = grant_idx_q;
      last_d      = last_q;
      served_d    = served_q;
      r_wn_d      = r_wn_q;
      byte_d      = byte_q;
      addr_d      = addr_q;
      case (state_q)
         ST_IDLE: begin
            if (sdram_init_done && !sdram_busy && win_valid) begin
               grant_d     = win_oh;
               grant_idx_d = win_idx;
               r_wn_d      = sel_r_wn;
               byte_d      = sel_byte;
               addr_d      = sel_addr;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (sdram_busy) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            served_d = served_q | sdram_wr_ack | sdram_rd_ack;
            // Busy dropping with no ack means a refresh took the slot: retry
            if (!sdram_busy) state_d = served_d ? ST_DONE : ST_ISSUE;
         end
         ST_DONE: begin
`ifdef SDRAM_ARB_PRIO_EN
            // Port 0 wins by priority, so it does not move the rotation pointer
            if (grant_idx_q != '0) last_d = grant_idx_q;
`else
            last_d = grant_idx_q;
`endif
            grant_d  = '0;
            served_d = 1'b0;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign sdram_wr_req = (state_q == ST_ISSUE) && !r_wn_q;
   assign sdram_rd_req = (state_q == ST_ISSUE) &&  r_wn_q;
   assign port_done    = (state_q == ST_DONE) ? grant_q : '0;
   assign port_wr_ack  = {N_PORTS{sdram_wr_ack}} & grant_q;
   assign port_rd_ack  = {N_PORTS{sdram_rd_ack}} & grant_q;
   assign grant        = grant_q;
   assign sdwr_byte    = byte_q;
   assign sdrd_byte    = byte_q;
   assign sdram_addr   = addr_q;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Bench for sdram_port_arb: a behavioural SDRAM controller answers requests,
// stimulus pushes the expected completion of each transaction into a queue,
// and a monitor pops and compares on every port_done pulse.
`timescale 1ns/1ps
module tb_sdram_port_arb;

   localparam int NP = 4;
   localparam int AW = 22;

   logic              clk = 1'b0;
   logic              rst;
   logic [NP-1:0]     port_req, port_r_wn;
   logic [9*NP-1:0]   port_byte;
   logic [AW*NP-1:0]  port_addr;
   logic [NP-1:0]     port_wr_ack, port_rd_ack, port_done, grant;
   logic              sdram_wr_req, sdram_rd_req;
   logic [8:0]        sdwr_byte, sdrd_byte;
   logic [AW-1:0]     sdram_addr;
   logic              sdram_wr_ack, sdram_rd_ack, sdram_busy, sdram_init_done;

   typedef struct {
      logic [NP-1:0] vec;
      int            port;
      logic          rd;
      int            len;
      logic [AW-1:0] addr;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   issue_cnt = 0;
   int   refresh_at = -1;
   int   acc_wr[NP];
   int   acc_rd[NP];

   sdram_port_arb #(.N_PORTS(NP), .ADDR_W(AW)) dut (
      .clk             (clk),
      .rst             (rst),
      .port_req        (port_req),
      .port_r_wn       (port_r_wn),
      .port_byte       (port_byte),
      .port_addr       (port_addr),
      .port_wr_ack     (port_wr_ack),
      .port_rd_ack     (port_rd_ack),
      .port_done       (port_done),
      .sdram_wr_req    (sdram_wr_req),
      .sdram_rd_req    (sdram_rd_req),
      .sdwr_byte       (sdwr_byte),
      .sdrd_byte       (sdrd_byte),
      .sdram_addr      (sdram_addr),
      .sdram_wr_ack    (sdram_wr_ack),
      .sdram_rd_ack    (sdram_rd_ack),
      .sdram_busy      (sdram_busy),
      .sdram_init_done (sdram_init_done),
      .grant           (grant)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   task automatic set_port(input int p, input logic rd, input int len, input logic [AW-1:0] addr);
      port_r_wn[p]         = rd;
      port_byte[p*9 +: 9]  = 9'(len);
      port_addr[p*AW +: AW] = addr;
   endtask

   task automatic push(input int p, input logic rd, input int len, input logic [AW-1:0] addr);
      exp_t e;
      e.vec = '0;
      e.vec[p] = 1'b1;
      e.port = p;
      e.rd = rd;
      e.len = len;
      e.addr = addr;
      exp_q.push_back(e);
   endtask

   // Wait for n done pulses; optionally each port drops its request on its own done
   task automatic wait_dones(input int n, input logic drop);
      int seen = 0;
      int cyc = 0;
      while (seen < n && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (port_done != '0) begin
            seen++;
            if (drop) port_req = port_req & ~port_done;
         end
      end
      check("done_count", 32'(seen), 32'(n));
   endtask

   task automatic wait_grant(input string name, input logic [NP-1:0] want);
      int cyc = 0;
      while (grant == '0 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check(name, 32'(grant), 32'(want));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Behavioural controller: busy one edge after a request, then len acks;
   // a request numbered refresh_at is swallowed by a 3-cycle ack-less busy.
   initial begin : ctrl
      int   len;
      logic is_rd;
      sdram_busy   = 1'b0;
      sdram_wr_ack = 1'b0;
      sdram_rd_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && (sdram_wr_req || sdram_rd_req)) begin
            issue_cnt++;
            is_rd = sdram_rd_req;
            len = int'(sdwr_byte);
            sdram_busy = 1'b1;
            if (issue_cnt == refresh_at) begin
               repeat (3) @(negedge clk);
            end else begin
               for (int i = 0; i < len; i++) begin
                  @(negedge clk);
                  if (rst) break;
                  if (is_rd) sdram_rd_ack = 1'b1;
                  else       sdram_wr_ack = 1'b1;
               end
               if (!rst) @(negedge clk);
            end
            sdram_wr_ack = 1'b0;
            sdram_rd_ack = 1'b0;
            sdram_busy   = 1'b0;
         end
      end
   end

   // Monitor: count routed strobes per port, compare on each done pulse
   initial begin : mon
      exp_t e;
      int   own;
      int   all;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            for (int p = 0; p < NP; p++) begin
               acc_wr[p] = 0;
               acc_rd[p] = 0;
            end
         end else begin
            for (int p = 0; p < NP; p++) begin
               if (port_wr_ack[p]) acc_wr[p]++;
               if (port_rd_ack[p]) acc_rd[p]++;
            end
            if (port_done != '0) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_done", 32'(port_done), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("done_port", 32'(port_done), 32'(e.vec));
                  check("grant_at_done", 32'(grant), 32'(e.vec));
                  check("addr_at_done", 32'(sdram_addr), 32'(e.addr));
                  check("byte_at_done", 32'(sdwr_byte), 32'(e.len));
                  own = e.rd ? acc_rd[e.port] : acc_wr[e.port];
                  all = 0;
                  for (int p = 0; p < NP; p++) all += acc_wr[p] + acc_rd[p];
                  check("ack_count", 32'(own), 32'(e.len));
                  check("stray_acks", 32'(all - own), 32'd0);
               end
               for (int p = 0; p < NP; p++) begin
                  acc_wr[p] = 0;
                  acc_rd[p] = 0;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin : stim
      logic any_req;
      logic any_grant;
      int   base;
      rst = 1'b1;
      port_req = '0;
      port_r_wn = '0;
      port_byte = '0;
      port_addr = '0;
      sdram_init_done = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_wr_req", 32'(sdram_wr_req), 32'd0);
      check("rst_rd_req", 32'(sdram_rd_req), 32'd0);
      check("rst_done", 32'(port_done), 32'd0);
      check("rst_addr", 32'(sdram_addr), 32'd0);
      check("rst_byte", 32'(sdrd_byte), 32'd0);
      rst = 1'b0;

      // Controller not initialised: nothing may be issued
      port_req = 4'b1111;
      any_req = 1'b0;
      any_grant = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (sdram_wr_req || sdram_rd_req) any_req = 1'b1;
         if (grant != '0) any_grant = 1'b1;
      end
      check("req_before_init", 32'(any_req), 32'd0);
      check("grant_before_init", 32'(any_grant), 32'd0);
      port_req = '0;
      @(negedge clk);
      sdram_init_done = 1'b1;
      @(negedge clk);

      // Single write from port 2
      set_port(2, 1'b0, 8, 22'h100);
      push(2, 1'b0, 8, 22'h100);
      port_req = 4'b0100;
      wait_grant("single_grant", 4'b0100);
      check("single_wr_req", 32'(sdram_wr_req), 32'd1);
      check("single_rd_req", 32'(sdram_rd_req), 32'd0);
      check("single_rd_byte", 32'(sdrd_byte), 32'd8);
      wait_dones(1, 1'b1);
      @(negedge clk);
      check("grant_idle", 32'(grant), 32'd0);

      // All ports requesting continuously
      do_reset();
      set_port(0, 1'b0, 4, 22'h10);
      set_port(1, 1'b1, 3, 22'h20);
      set_port(2, 1'b0, 2, 22'h30);
      set_port(3, 1'b1, 5, 22'h40);
`ifdef SDRAM_ARB_PRIO_EN
      push(0, 1'b0, 4, 22'h10);
      push(0, 1'b0, 4, 22'h10);
      push(0, 1'b0, 4, 22'h10);
      port_req = 4'b0011;
      wait_dones(3, 1'b0);
      port_req = 4'b0010;
      push(1, 1'b1, 3, 22'h20);
      wait_dones(1, 1'b1);
`else
      push(0, 1'b0, 4, 22'h10);
      push(1, 1'b1, 3, 22'h20);
      push(2, 1'b0, 2, 22'h30);
      push(3, 1'b1, 5, 22'h40);
      push(0, 1'b0, 4, 22'h10);
      port_req = 4'b1111;
      wait_dones(5, 1'b0);
      port_req = '0;
`endif
      repeat (3) @(negedge clk);

      // Refresh steals the first issue; same grant must re-issue once
      set_port(1, 1'b1, 6, 22'h2A0);
      push(1, 1'b1, 6, 22'h2A0);
      base = issue_cnt;
      refresh_at = issue_cnt + 1;
      port_req = 4'b0010;
      wait_dones(1, 1'b1);
      check("reissue_count", 32'(issue_cnt - base), 32'd2);
      repeat (2) @(negedge clk);

      // Reset in the middle of a 16-word read on port 1
      set_port(1, 1'b1, 16, 22'h3000);
      port_req = 4'b0010;
      wait_grant("abort_grant", 4'b0010);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_grant_zero", 32'(grant), 32'd0);
      check("abort_rd_req", 32'(sdram_rd_req), 32'd0);
      check("abort_rd_ack", 32'(port_rd_ack), 32'd0);
      check("abort_done", 32'(port_done), 32'd0);
      check("abort_addr", 32'(sdram_addr), 32'd0);
      check("abort_byte", 32'(sdwr_byte), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      set_port(0, 1'b0, 3, 22'h50);
      push(0, 1'b0, 3, 22'h50);
      push(1, 1'b1, 16, 22'h3000);
      port_req = 4'b0011;
      wait_dones(2, 1'b1);

      repeat (5) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
